agc_breakpoint_unit: RTL

Parametrised run-control and breakpoint engine for the AGC monitor. It replaces the single fixed breakpoint with NUM_BP independent address/bank comparators, each carrying a pass count, and owns the MSTP run/step/halt state machine. It sits between the virtual-JTAG register shim, which drives the cfg_* port, and the AGC monitor signals (MNISQ, MT01, MWG, mirrored S/BB). Its output MSTP replaces the CONTROL-bit-driven MSTP.

---
 rtl/agc_monitor_pkg.sv | 35 +++
 rtl/agc_breakpoint_unit_if.sv | 14 +
 rtl/agc_bp_comparator.sv | 78 +++++++
 rtl/agc_breakpoint_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/agc_monitor_pkg.sv
// rtl/agc_monitor_pkg.sv - shared types, register map and helpers for the AGC breakpoint unit
package agc_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STEP   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_HALT  = 3'd1;
    localparam logic [2:0] CAUSE_STEP  = 3'd2;
    localparam logic [2:0] CAUSE_BP    = 3'd3;
    localparam logic [2:0] CAUSE_WATCH = 3'd4;

    localparam int CTRL_HALT  = 0;
    localparam int CTRL_RUN   = 1;
    localparam int CTRL_STEP  = 2;
    localparam int CTRL_STYPE = 3;
    localparam int CTRL_GBE   = 4;

    localparam int REG_CTRL  = 0;
    localparam int REG_STAT  = 1;
    localparam int BP_BASE   = 2;
    localparam int BP_STRIDE = 3;

    // Superbank FB values (11xxx) need the FEB bits too; otherwise FB alone decides.
    function automatic logic bank_match(input logic [14:0] bb, input logic [10:0] bank);
        if (bb[14:13] == 2'b11)
            return bb[14:4] == bank;
        else
            return bb[14:10] == bank[10:6];
    endfunction

endpackage

// File: rtl/agc_breakpoint_unit_if.sv
// rtl/agc_breakpoint_unit_if.sv - configuration register bus between the JTAG shim and the breakpoint unit
interface agc_breakpoint_unit_if #(
    parameter int NUM_BP = 4
);
    localparam int CFG_AW = $clog2(2 + 3 * NUM_BP);

    logic              cfg_we;
    logic [CFG_AW-1:0] cfg_addr;
    logic [15:0]       cfg_wdata;
    logic [15:0]       cfg_rdata;

    modport master (output cfg_we, cfg_addr, cfg_wdata, input cfg_rdata);
    modport slave  (input cfg_we, cfg_addr, cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/agc_bp_comparator.sv
// rtl/agc_bp_comparator.sv - one address/bank comparator with pass counter and its config registers
// Watch mode (MWG qualified) exists only when WATCHPOINT_EN is defined.
module agc_bp_comparator
    import agc_monitor_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gbe,
    input  logic        we_addr,
    input  logic        we_bank,
    input  logic        we_cnt,
    input  logic [15:0] wdata,
    input  logic [11:0] s_reg,
    input  logic [14:0] bb_reg,
    input  logic        mnisq,
    input  logic        mwg,
    output logic        halt_req,
    output logic        is_watch,
    output logic [15:0] rd_addr,
    output logic [15:0] rd_bank,
    output logic [15:0] rd_cnt
);
    logic             en_q;
    logic [11:0]      addr_q;
    logic [10:0]      bank_q;
    logic [CNT_W-1:0] cnt_q;
    logic             qual;
    logic             match;
    logic             unused_in;

`ifdef WATCHPOINT_EN
    logic watch_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            watch_q <= 1'b0;
        else if (we_addr)
            watch_q <= wdata[14];
    end
    assign is_watch  = watch_q;
    assign qual      = watch_q ? mwg : mnisq;
    assign unused_in = ^bb_reg[3:0];
`else
    assign is_watch  = 1'b0;
    assign qual      = mnisq;
    assign unused_in = ^{bb_reg[3:0], mwg};
`endif

    assign match = en_q && gbe && (s_reg == addr_q) &&
                   ((s_reg[11:10] != 2'b01) || bank_match(bb_reg, bank_q)) && qual;
    assign halt_req = match && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            bank_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (we_addr) begin
                en_q   <= wdata[15];
                addr_q <= wdata[11:0];
            end
            if (we_bank)
                bank_q <= wdata[14:4];
            // A config write beats a same-cycle decrement.
            if (we_cnt)
                cnt_q <= wdata[CNT_W-1:0];
            else if (match && cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
        end
    end

    assign rd_addr = {en_q, is_watch, 2'b00, addr_q};
    assign rd_bank = {1'b0, bank_q, 4'b0000};
    assign rd_cnt  = 16'(cnt_q);
endmodule

// File: rtl/agc_breakpoint_unit.sv
// rtl/agc_breakpoint_unit.sv - NUM_BP breakpoint comparators plus the MSTP run/step/halt machine
// Optional watchpoints: define WATCHPOINT_EN.
module agc_breakpoint_unit
    import agc_monitor_pkg::*;
#(
    parameter int NUM_BP = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   SIM_CLK,
    input  logic                   SIM_RST,
    agc_breakpoint_unit_if.slave   cfg,
    input  logic                   MNISQ,
    input  logic                   MT01,
    input  logic                   MWG,
    input  logic [11:0]            s_reg,
    input  logic [14:0]            bb_reg,
    output logic                   MSTP,
    output logic                   halted,
    output logic [3:0]             hit_id
);
    localparam int CFG_AW = $clog2(2 + 3 * NUM_BP);

    logic [CFG_AW-1:0] addr;
    logic              ctrl_wr, halt_cmd, run_cmd, step_cmd;
    state_t            state_q, state_n;
    logic [2:0]        cause_q, cause_n;
    logic [3:0]        hit_q, hit_n;
    logic              gbe_q, step_instr_q, step_instr_n;
    logic [15:0]       rdata_q, rdata_n;

    logic [NUM_BP-1:0] halt_req, is_watch;
    logic [15:0]       rd_addr [NUM_BP];
    logic [15:0]       rd_bank [NUM_BP];
    logic [15:0]       rd_cnt  [NUM_BP];
    logic              bp_halt, win_watch;
    logic [3:0]        win_idx;

    assign addr     = cfg.cfg_addr;
    assign ctrl_wr  = cfg.cfg_we && (addr == CFG_AW'(REG_CTRL));
    assign halt_cmd = ctrl_wr && cfg.cfg_wdata[CTRL_HALT];
    assign run_cmd  = ctrl_wr && cfg.cfg_wdata[CTRL_RUN];
    assign step_cmd = ctrl_wr && cfg.cfg_wdata[CTRL_STEP];

    for (genvar g = 0; g < NUM_BP; g++) begin : g_bp
        agc_bp_comparator #(.CNT_W(CNT_W)) u_bp (
            .clk      (SIM_CLK),
            .rst      (SIM_RST),
            .gbe      (gbe_q),
            .we_addr  (cfg.cfg_we && int'(addr) == BP_BASE + BP_STRIDE * g),
            .we_bank  (cfg.cfg_we && int'(addr) == BP_BASE + BP_STRIDE * g + 1),
            .we_cnt   (cfg.cfg_we && int'(addr) == BP_BASE + BP_STRIDE * g + 2),
            .wdata    (cfg.cfg_wdata),
            .s_reg    (s_reg),
            .bb_reg   (bb_reg),
            .mnisq    (MNISQ),
            .mwg      (MWG),
            .halt_req (halt_req[g]),
            .is_watch (is_watch[g]),
            .rd_addr  (rd_addr[g]),
            .rd_bank  (rd_bank[g]),
            .rd_cnt   (rd_cnt[g])
        );
    end

    // Lowest index wins: scan downward so the last assignment is the smallest hit.
    always_comb begin
        win_idx   = '0;
        win_watch = 1'b0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (halt_req[i]) begin
                win_idx   = 4'(i);
                win_watch = is_watch[i];
            end
        end
    end
    assign bp_halt = |halt_req;

    always_comb begin
        state_n      = state_q;
        cause_n      = cause_q;
        hit_n        = hit_q;
        step_instr_n = step_instr_q;
        case (state_q)
            ST_RUN, ST_STEP: begin
                if (halt_cmd) begin
                    state_n = ST_HALTED;
                    cause_n = CAUSE_HALT;
                end else if (bp_halt) begin
                    state_n = ST_HALTED;
                    cause_n = win_watch ? CAUSE_WATCH : CAUSE_BP;
                    hit_n   = win_idx;
                end else if (state_q == ST_STEP && (step_instr_q ? MNISQ : MT01)) begin
                    state_n = ST_HALTED;
                    cause_n = CAUSE_STEP;
                end
            end
            ST_HALTED: begin
                if (run_cmd) begin
                    state_n = ST_RUN;
                end else if (step_cmd) begin
                    state_n      = ST_STEP;
                    step_instr_n = cfg.cfg_wdata[CTRL_STYPE];
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    always_comb begin
        rdata_n = '0;
        if (int'(addr) == REG_STAT)
            rdata_n = {4'b0000, hit_q, gbe_q, 2'b00, cause_q, state_q};
        for (int i = 0; i < NUM_BP; i++) begin
            if (int'(addr) == BP_BASE + BP_STRIDE * i)     rdata_n = rd_addr[i];
            if (int'(addr) == BP_BASE + BP_STRIDE * i + 1) rdata_n = rd_bank[i];
            if (int'(addr) == BP_BASE + BP_STRIDE * i + 2) rdata_n = rd_cnt[i];
        end
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_q      <= ST_RUN;
            cause_q      <= CAUSE_NONE;
            hit_q        <= '0;
            gbe_q        <= 1'b0;
            step_instr_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_n;
            cause_q      <= cause_n;
            hit_q        <= hit_n;
            step_instr_q <= step_instr_n;
            rdata_q      <= rdata_n;
            if (ctrl_wr)
                gbe_q <= cfg.cfg_wdata[CTRL_GBE];
        end
    end

    assign MSTP          = (state_q == ST_HALTED);
    assign halted        = (state_q == ST_HALTED);
    assign hit_id        = hit_q;
    assign cfg.cfg_rdata = rdata_q;
endmodule
